// File: rtl/dense_25d_seq.sv
// dense_25d_seq
// Job sequencer for the 2.5D dense datapath. It fills the dense shift
// register with SR_FILL pixel vectors, streams one extra vector per
// additional window, then waits for the PIPE_LAT-deep datapath to drain
// before signalling completion.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   start      job request, honoured only in IDLE
//   abort      synchronous job cancel (ignored in IDLE)
//   in_valid   upstream pixel vector present
//   in_ready   sequencer accepts a pixel vector (FILL / STREAM)
//   sr_en      shift enable to the dense shift register (in_valid & in_ready)
//   sr_clr     one-cycle flush pulse on job start and on abort
//   out_valid  datapath output holds a valid result
//   out_idx    window index of the current result
//   busy       high in every state except IDLE
//   done       one-cycle job-complete pulse
module dense_25d_seq #(
    parameter int SR_FILL     = 16,
    parameter int PIPE_LAT    = 7,
    parameter int NUM_WINDOWS = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sr_en,
    output logic             sr_clr,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Pre-increment pix_cnt values of interest.
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(SR_FILL - 1);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(SR_FILL + NUM_WINDOWS - 2);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(NUM_WINDOWS - 1);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [CNT_W-1:0]    pix_cnt;
    logic [CNT_W-1:0]    out_cnt;
    logic [PIPE_LAT-1:0] vld_p;
    logic                accept;
    logic                win_fire;
    logic                last_acc;
    logic                start_job;
    logic                kill;
    logic                clr;

    assign in_ready  = (state == S_FILL) || (state == S_STREAM);
    assign sr_en     = in_valid & in_ready;
    assign accept    = sr_en;
    assign win_fire  = accept && (pix_cnt >= FILL_LAST);
    assign last_acc  = accept && (pix_cnt == ACC_LAST);

    assign start_job = (state == S_IDLE) && start;
    assign kill      = (state != S_IDLE) && abort;
    assign clr       = start_job || kill;

    // start/abort are raw inputs, so the flush pulse is masked while the
    // block is held in reset.
    assign sr_clr    = reset & clr;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign out_valid = vld_p[PIPE_LAT-1];
    assign out_idx   = out_cnt;

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_nxt = S_FILL;
                // The final-accept check comes first so a one-window job
                // with SR_FILL=1 goes straight from FILL to DRAIN.
                S_FILL: begin
                    if (last_acc)
                        state_nxt = S_DRAIN;
                    else if (accept && (pix_cnt == FILL_LAST))
                        state_nxt = S_STREAM;
                end
                S_STREAM: if (last_acc) state_nxt = S_DRAIN;
                S_DRAIN:  if (out_valid && (out_cnt == OUT_LAST)) state_nxt = S_DONE;
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            pix_cnt <= '0;
            out_cnt <= '0;
            vld_p   <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                pix_cnt <= '0;
                out_cnt <= '0;
                vld_p   <= '0;
            end else begin
                if (accept)
                    pix_cnt <= pix_cnt + CNT_W'(1);
                if (out_valid)
                    out_cnt <= out_cnt + CNT_W'(1);
                // Valid pipe: tracks datapath latency, shifts even when stalled.
                vld_p[0] <= win_fire;
                for (int i = 1; i < PIPE_LAT; i++)
                    vld_p[i] <= vld_p[i-1];
            end
        end
    end

endmodule

// File: tb/tb_dense_25d_seq.sv
module tb_dense_25d_seq;

    localparam int SR_FILL     = 16;
    localparam int PIPE_LAT    = 7;
    localparam int NUM_WINDOWS = 2;
    localparam int CNT_W       = 16;

    logic             clock;
    logic             reset;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic             sr_en;
    logic             sr_clr;
    logic             out_valid;
    logic [CNT_W-1:0] out_idx;
    logic             busy;
    logic             done;

    dense_25d_seq #(
        .SR_FILL    (SR_FILL),
        .PIPE_LAT   (PIPE_LAT),
        .NUM_WINDOWS(NUM_WINDOWS),
        .CNT_W      (CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sr_en    (sr_en),
        .sr_clr   (sr_clr),
        .out_valid(out_valid),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Expected event cycles, filled by the stimulus, drained by the monitor.
    int acc_q[$];
    int clr_q[$];
    int done_q[$];
    int out_cyc_q[$];
    int out_idx_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed event must match the head of its queue.
    always @(negedge clock) begin
        if (reset) begin
            if (sr_en) begin
                if (acc_q.size() == 0) chk("unexpected accept", 1, 0);
                else chk("accept cycle", cyc, acc_q.pop_front());
            end
            if (sr_clr) begin
                if (clr_q.size() == 0) chk("unexpected sr_clr", 1, 0);
                else chk("sr_clr cycle", cyc, clr_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected done", 1, 0);
                else chk("done cycle", cyc, done_q.pop_front());
            end
            if (out_valid) begin
                if (out_cyc_q.size() == 0) chk("unexpected out_valid", 1, 0);
                else begin
                    chk("out_valid cycle", cyc, out_cyc_q.pop_front());
                    chk("out_idx", out_idx, out_idx_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one job starting in the current cycle (offset 0).
    task automatic run(input int len, input int gap_from, input int gap_len,
                       input int abort_at, input int start_until);
        for (int off = 0; off < len; off++) begin
            start    = (off <= start_until);
            abort    = (off == abort_at);
            in_valid = !((off >= gap_from) && (off < gap_from + gap_len));
            step();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic push_acc(input int s, input int first_off, input int count);
        for (int k = 0; k < count; k++) acc_q.push_back(s + first_off + k);
    endtask

    task automatic push_out(input int c, input int idx);
        out_cyc_q.push_back(c);
        out_idx_q.push_back(idx);
    endtask

    // Uninterrupted default job starting at cycle s.
    task automatic push_std(input int s);
        clr_q.push_back(s);
        push_acc(s, 1, 17);
        push_out(s + 23, 0);
        push_out(s + 24, 1);
        done_q.push_back(s + 25);
    endtask

    task automatic flush(input string name);
        chk({name, " missing accepts"}, acc_q.size(), 0);
        chk({name, " missing sr_clr"}, clr_q.size(), 0);
        chk({name, " missing done"}, done_q.size(), 0);
        chk({name, " missing out_valid"}, out_cyc_q.size(), 0);
        acc_q.delete();
        clr_q.delete();
        done_q.delete();
        out_cyc_q.delete();
        out_idx_q.delete();
    endtask

    int s;

    initial begin
        reset    = 1'b0;
        start    = 1'b1;
        abort    = 1'b1;
        in_valid = 1'b1;
        repeat (3) step();
        chk("reset in_ready", in_ready, 0);
        chk("reset sr_en", sr_en, 0);
        chk("reset sr_clr", sr_clr, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_idx", out_idx, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);

        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("idle after release", busy, 0);

        // abort in IDLE does nothing
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort in idle busy", busy, 0);
        step();

        // basic job, in_valid held high
        s = cyc;
        push_std(s);
        run(30, 1000, 0, -1, 0);
        chk("basic busy after", busy, 0);
        flush("basic");

        // 3-cycle stall after accept 10
        s = cyc;
        clr_q.push_back(s);
        push_acc(s, 1, 10);
        push_acc(s, 14, 7);
        push_out(s + 26, 0);
        push_out(s + 27, 1);
        done_q.push_back(s + 28);
        run(32, 11, 3, -1, 0);
        chk("stall busy after", busy, 0);
        flush("stall");

        // stall between accepts 16 and 17
        s = cyc;
        clr_q.push_back(s);
        push_acc(s, 1, 16);
        acc_q.push_back(s + 19);
        push_out(s + 23, 0);
        push_out(s + 26, 1);
        done_q.push_back(s + 27);
        run(32, 17, 2, -1, 0);
        chk("gap busy after", busy, 0);
        flush("gap");

        // abort in DRAIN with one result still in the pipe
        s = cyc;
        clr_q.push_back(s);
        clr_q.push_back(s + 23);
        push_acc(s, 1, 17);
        push_out(s + 23, 0);
        run(24, 1000, 0, 23, 0);
        chk("abort idle next cycle", busy, 0);
        chk("abort no done", done, 0);
        repeat (6) step();
        flush("abort");

        s = cyc;
        push_std(s);
        run(30, 1000, 0, -1, 0);
        chk("post-abort busy after", busy, 0);
        flush("post-abort");

        // asynchronous reset mid-STREAM (in_valid stalled after accept 16)
        s = cyc;
        clr_q.push_back(s);
        push_acc(s, 1, 16);
        run(19, 17, 100, -1, 0);
        chk("pre-reset busy", busy, 1);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset in_ready", in_ready, 0);
        chk("mid reset out_valid", out_valid, 0);
        chk("mid reset out_idx", out_idx, 0);
        chk("mid reset done", done, 0);
        step();
        step();
        reset = 1'b1;
        repeat (15) step();
        chk("post reset busy", busy, 0);
        flush("reset");

        // start held high through the whole job including DONE
        s = cyc;
        push_std(s);
        run(30, 1000, 0, -1, 25);
        chk("held start busy after", busy, 0);
        step();
        chk("held start stays idle", busy, 0);
        flush("held start");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
